// File: rtl/z80_bank_serializer.sv
// rtl/z80_bank_serializer.sv - serial writer for the Z80 bank register, LSB first, with gap timing and ack timeout
module z80_bank_serializer #(
  parameter int BANK_W  = 9,
  parameter int GAP_CYC = 1,
  parameter int TMO_CYC = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [BANK_W-1:0] bank_in,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              wr_req,
  output logic              wr_d0,
  output logic [3:0]        bit_idx
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [BANK_W-1:0] shreg_q, shreg_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [3:0]        gap_q, gap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              wr_req_q, wr_req_d;
  logic              wr_d0_q, wr_d0_d;
  logic [8:0]        tmo_inc;

  // Next-state logic: every output is computed here one cycle ahead and registered
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    tmo_d     = tmo_q;
    gap_d     = gap_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    wr_req_d  = wr_req_q;
    wr_d0_d   = wr_d0_q;
    tmo_inc   = {1'b0, tmo_q} + 9'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bank_in;
          bit_idx_d = 4'd0;
          tmo_d     = 8'd0;
          busy_d    = 1'b1;
          wr_req_d  = 1'b1;
          wr_d0_d   = bank_in[0];
          state_d   = REQ;
        end
      end
      REQ: begin
        if (wr_ack) begin
          wr_req_d = 1'b0;
          if (bit_idx_q == 4'(BANK_W - 1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_idx_d = bit_idx_q + 4'd1;
            gap_d     = 4'(GAP_CYC);
            state_d   = GAP;
          end
        end else begin
          // Saturate so a disabled timeout never wraps into a false match
          tmo_d = (tmo_q == 8'hFF) ? tmo_q : tmo_inc[7:0];
          if ((TMO_CYC != 0) && (tmo_inc == 9'(TMO_CYC))) begin
            // Abort: remaining bits are dropped, bit_idx kept for debug
            wr_req_d = 1'b0;
            busy_d   = 1'b0;
            err_d    = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q <= 4'd1) begin
          wr_req_d = 1'b1;
          wr_d0_d  = shreg_q[0];
          tmo_d    = 8'd0;
          state_d  = REQ;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        wr_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset to all-zero / IDLE
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= 4'd0;
      tmo_q     <= 8'd0;
      gap_q     <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wr_req_q  <= 1'b0;
      wr_d0_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      wr_req_q  <= wr_req_d;
      wr_d0_q   <= wr_d0_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign wr_req  = wr_req_q;
  assign wr_d0   = wr_d0_q;
  assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_z80_bank_serializer.sv
// tb/tb_z80_bank_serializer.sv - directed scoreboard bench for z80_bank_serializer
module tb_z80_bank_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [8:0] bank_in;
  logic       wr_ack;
  logic       busy_a, done_a, err_a, req_a, d0_a;
  logic [3:0] idx_a;
  logic       busy_b, done_b, err_b, req_b, d0_b;
  logic [3:0] idx_b;

  logic       sel;
  logic       obs_req, obs_d0, obs_done, obs_err, obs_busy;
  logic [3:0] obs_idx;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  done_cnt = 0;
  int  err_cnt  = 0;
  bit  ack_en;
  int  ack_delay;
  logic exp_q[$];

  always #5 clk = ~clk;

  z80_bank_serializer #(.BANK_W(9), .GAP_CYC(1), .TMO_CYC(16)) dut (
    .CLK(clk), .RESET(rst), .start(start_a), .bank_in(bank_in), .wr_ack(wr_ack),
    .busy(busy_a), .done(done_a), .err(err_a), .wr_req(req_a), .wr_d0(d0_a), .bit_idx(idx_a)
  );

  z80_bank_serializer #(.BANK_W(9), .GAP_CYC(1), .TMO_CYC(0)) dut_nt (
    .CLK(clk), .RESET(rst), .start(start_b), .bank_in(bank_in), .wr_ack(wr_ack),
    .busy(busy_b), .done(done_b), .err(err_b), .wr_req(req_b), .wr_d0(d0_b), .bit_idx(idx_b)
  );

  assign obs_req  = sel ? req_b  : req_a;
  assign obs_d0   = sel ? d0_b   : d0_a;
  assign obs_done = sel ? done_b : done_a;
  assign obs_err  = sel ? err_b  : err_a;
  assign obs_busy = sel ? busy_b : busy_a;
  assign obs_idx  = sel ? idx_b  : idx_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [8:0] v, input int npush);
    for (int i = 0; i < npush; i++) exp_q.push_back(v[i]);
    bank_in = v;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!obs_done && n < limit) begin
      tick();
      n++;
    end
    check("done_seen", obs_done, 1);
  endtask

  // Bus responder and scoreboard monitor, sampled on the falling edge
  initial begin
    logic prev_req;
    logic held;
    int   rcnt;
    prev_req = 1'b0;
    held     = 1'b0;
    rcnt     = 0;
    wr_ack   = 1'b0;
    forever begin
      @(negedge clk);
      if (obs_req) begin
        if (!prev_req) begin
          rcnt = 0;
          check("write_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("wr_d0_bit", obs_d0, exp_q.pop_front());
          held = obs_d0;
        end else begin
          rcnt++;
          check("wr_d0_stable", obs_d0, held);
        end
        wr_ack = ack_en && (rcnt >= ack_delay);
      end else begin
        wr_ack = 1'b0;
      end
      if (obs_done) done_cnt++;
      if (obs_err) err_cnt++;
      if (obs_done || obs_err) check("done_err_exclusive", obs_done & obs_err, 0);
      prev_req = obs_req;
    end
  end

  initial begin
    int d0, e0;
    sel = 1'b0; rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bank_in = 9'h0;
    ack_en = 1'b1; ack_delay = 0;
    tick(); tick(); tick();

    // Reset state
    check("rst_wr_req", req_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_wr_d0", d0_a, 0);
    check("rst_bit_idx", idx_a, 0);
    rst = 1'b0;
    tick();

    // Basic transfer, ack tied high, exact cycle timing
    d0 = done_cnt;
    start_xfer(9'h1A5, 9);
    for (int k = 1; k <= 18; k++) begin
      check($sformatf("basic_wr_req_t%0d", k), req_a, (k <= 17) && (k % 2 == 1));
      check($sformatf("basic_busy_t%0d", k), busy_a, (k <= 17));
      check($sformatf("basic_done_t%0d", k), done_a, (k == 18));
      tick();
    end
    check("basic_done_count", done_cnt, d0 + 1);
    check("basic_sb_empty", exp_q.size(), 0);

    // Delayed ack: three stall cycles per write
    d0 = done_cnt; e0 = err_cnt;
    ack_delay = 3;
    start_xfer(9'h0FF, 9);
    wait_done(200);
    tick();
    check("delay_done_count", done_cnt, d0 + 1);
    check("delay_err_count", err_cnt, e0);
    check("delay_sb_empty", exp_q.size(), 0);

    // Timeout: ack never arrives
    d0 = done_cnt; e0 = err_cnt;
    ack_en = 1'b0; ack_delay = 0;
    start_xfer(9'h1A5, 1);
    for (int k = 1; k <= 16; k++) begin
      check($sformatf("tmo_wr_req_t%0d", k), req_a, 1);
      check($sformatf("tmo_err_t%0d", k), err_a, 0);
      tick();
    end
    check("tmo_wr_req_drop", req_a, 0);
    check("tmo_err_pulse", err_a, 1);
    check("tmo_busy", busy_a, 0);
    check("tmo_done", done_a, 0);
    check("tmo_bit_idx", idx_a, 0);
    tick();
    check("tmo_err_one_cycle", err_a, 0);
    check("tmo_err_count", err_cnt, e0 + 1);
    check("tmo_no_done", done_cnt, d0);
    ack_en = 1'b1;
    start_xfer(9'h0AB, 9);
    check("tmo_restart_req", req_a, 1);
    wait_done(100);
    tick();
    check("tmo_restart_done", done_cnt, d0 + 1);

    // Ignored start mid-transfer, then start in the done cycle
    d0 = done_cnt;
    start_xfer(9'h155, 9);
    tick(); tick(); tick();
    bank_in = 9'h0AA; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_done(100);
    for (int i = 0; i < 9; i++) exp_q.push_back(1'(9'h033 >> i));
    bank_in = 9'h033; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("done_cycle_start_req", req_a, 1);
    check("done_cycle_start_busy", busy_a, 1);
    wait_done(100);
    tick();
    check("ign_done_count", done_cnt, d0 + 2);
    check("ign_sb_empty", exp_q.size(), 0);

    // Reset during the third REQ
    d0 = done_cnt; e0 = err_cnt;
    start_xfer(9'h1FF, 3);
    tick(); tick(); tick(); tick();
    check("rstmid_third_req", req_a, 1);
    check("rstmid_third_idx", idx_a, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_wr_req", req_a, 0);
    check("rstmid_busy", busy_a, 0);
    check("rstmid_bit_idx", idx_a, 0);
    check("rstmid_done", done_a, 0);
    check("rstmid_err", err_a, 0);
    tick(); tick();
    check("rstmid_no_done", done_cnt, d0);
    check("rstmid_no_err", err_cnt, e0);
    check("rstmid_sb_empty", exp_q.size(), 0);
    start_xfer(9'h001, 9);
    wait_done(100);
    tick();
    check("rstmid_after_done", done_cnt, d0 + 1);

    // Timeout disabled: each ack withheld for 300 cycles
    sel = 1'b1;
    tick();
    d0 = done_cnt; e0 = err_cnt;
    ack_delay = 300;
    start_xfer(9'h0B6, 9);
    wait_done(4000);
    tick();
    check("notmo_no_err", err_cnt, e0);
    check("notmo_done_count", done_cnt, d0 + 1);
    check("notmo_sb_empty", exp_q.size(), 0);
    check("notmo_busy_clear", obs_busy, 0);
    check("notmo_bit_idx", obs_idx, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
